// File: rtl/key_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : key_scheduler
// Description : Serially loads a key pair and presents the two keys
//               alternately, SLOT_LEN cycles each, while running.
// Revision    : 1.0 - initial release
// ============================================================================
module key_scheduler #(
    parameter int KEY_W    = 5,
    parameter int SLOT_LEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             sdi,
    input  logic             start,
    input  logic             stop,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             slot,
    output logic             loaded,
    output logic             err
);

    localparam int c_TOTAL_BITS = 2 * KEY_W;
    localparam int c_CNT_W      = $clog2(c_TOTAL_BITS + 1);
    localparam int c_CYC_W      = $clog2(2 * SLOT_LEN);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_TOTAL_BITS - 1);
    localparam logic [c_CYC_W-1:0] c_CYC_ONE  = c_CYC_W'(1);
    localparam logic [c_CYC_W-1:0] c_CYC_MAX  = c_CYC_W'(2 * SLOT_LEN - 1);
    localparam logic [c_CYC_W-1:0] c_CYC_SLOT = c_CYC_W'(SLOT_LEN);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_ARMED = 2'd2;
    localparam logic [1:0] c_RUN   = 2'd3;

    logic [1:0]              r_state;
    logic [c_TOTAL_BITS-1:0] r_shift;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic [KEY_W-1:0]        r_key1;
    logic [KEY_W-1:0]        r_key2;
    logic [c_CYC_W-1:0]      r_cyc;
    logic                    r_load_d;
    logic [KEY_W-1:0]        r_key;
    logic                    r_key_valid;
    logic                    r_slot;
    logic                    r_loaded;
    logic                    r_err;

    logic [1:0]              w_state_nxt;
    logic [c_TOTAL_BITS-1:0] w_shift_nxt;
    logic [c_TOTAL_BITS-1:0] w_shift_in;
    logic [c_CNT_W-1:0]      w_bit_cnt_nxt;
    logic [KEY_W-1:0]        w_key1_nxt;
    logic [KEY_W-1:0]        w_key2_nxt;
    logic [c_CYC_W-1:0]      w_cyc_nxt;
    logic                    w_loaded_nxt;
    logic                    w_err_nxt;
    logic                    w_run_nxt;
    logic                    w_slot_nxt;

    assign w_shift_in = {r_shift[c_TOTAL_BITS-2:0], sdi};

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_key1_nxt    = r_key1;
        w_key2_nxt    = r_key2;
        w_cyc_nxt     = r_cyc;
        w_loaded_nxt  = r_loaded;
        w_err_nxt     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (load) begin
                    w_shift_nxt   = w_shift_in;
                    w_bit_cnt_nxt = c_CNT_ONE;
                    w_state_nxt   = c_LOAD;
                end
            end
            c_LOAD: begin
                if (load) begin
                    w_shift_nxt = w_shift_in;
                    if (r_bit_cnt == c_CNT_LAST) begin
                        // First-shifted bits form key1, MSB first
                        w_key1_nxt    = w_shift_in[c_TOTAL_BITS-1:KEY_W];
                        w_key2_nxt    = w_shift_in[KEY_W-1:0];
                        w_loaded_nxt  = 1'b1;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = c_ARMED;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                    end
                end else begin
                    w_err_nxt     = 1'b1;
                    w_shift_nxt   = '0;
                    w_bit_cnt_nxt = '0;
                    w_loaded_nxt  = 1'b0;
                    w_state_nxt   = c_IDLE;
                end
            end
            c_ARMED: begin
                if (load) begin
                    w_loaded_nxt  = 1'b0;
                    w_shift_nxt   = w_shift_in;
                    w_bit_cnt_nxt = c_CNT_ONE;
                    w_state_nxt   = c_LOAD;
                end else if (start) begin
                    w_cyc_nxt   = '0;
                    w_state_nxt = c_RUN;
                end
            end
            default: begin
                // Load is never honoured while running; flag it instead
                w_err_nxt = load & (stop | ~r_load_d);
                if (stop) begin
                    w_cyc_nxt   = '0;
                    w_state_nxt = c_ARMED;
                end else if (r_cyc == c_CYC_MAX) begin
                    w_cyc_nxt = '0;
                end else begin
                    w_cyc_nxt = r_cyc + c_CYC_ONE;
                end
            end
        endcase
    end

    // Outputs are registered from next-state values so the first key appears
    // on the same edge that enters RUN.
    assign w_run_nxt  = (w_state_nxt == c_RUN);
    assign w_slot_nxt = w_run_nxt && (w_cyc_nxt >= c_CYC_SLOT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_key1      <= '0;
            r_key2      <= '0;
            r_cyc       <= '0;
            r_load_d    <= 1'b0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_slot      <= 1'b0;
            r_loaded    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_key1      <= w_key1_nxt;
            r_key2      <= w_key2_nxt;
            r_cyc       <= w_cyc_nxt;
            r_load_d    <= load;
            r_key       <= w_run_nxt ? (w_slot_nxt ? w_key2_nxt : w_key1_nxt) : '0;
            r_key_valid <= w_run_nxt;
            r_slot      <= w_slot_nxt;
            r_loaded    <= w_loaded_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign slot      = r_slot;
    assign loaded    = r_loaded;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/key_scheduler.md
KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 Parameter KEY_W, default 5, width of each key word and of the key output bus.
REQ-002 Parameter SLOT_LEN, default 2, clock cycles each key is held per schedule period.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load  input  1  serial load enable, high for the whole key transfer.
REQ-006 sdi  input  1  serial key data bit, sampled when load=1.
REQ-007 start  input  1  begin key schedule, sampled in ARMED only.
REQ-008 stop  input  1  end key schedule, sampled in RUN only.
REQ-009 key  output  KEY_W  current key word; bit i drives keyinput i of the locked FSM.
REQ-010 key_valid  output  1  high while key carries a scheduled key.
REQ-011 slot  output  1  0 = key1 presented, 1 = key2 presented.
REQ-012 loaded  output  1  high when a complete key pair is held.
REQ-013 err  output  1  one-cycle pulse on protocol violation.

Function
REQ-014 The block SHALL implement states IDLE, LOAD, ARMED, RUN; all outputs SHALL be registered.
REQ-015 In IDLE, load=1 SHALL shift sdi into the shift register, set bit_cnt=1 and enter LOAD.
REQ-016 In LOAD, each cycle with load=1 SHALL shift one sdi bit, MSB first, key1 then key2, 2*KEY_W bits total.
REQ-017 On the cycle the 2*KEY_W-th bit is shifted, the block SHALL latch key1/key2, set loaded=1 and enter ARMED.
REQ-018 If load falls in LOAD before 2*KEY_W bits, the block SHALL discard the partial data, pulse err, and enter IDLE with loaded=0.
REQ-019 In ARMED, load=1 SHALL clear loaded and start a new LOAD (first bit shifted that cycle); load SHALL take priority over a simultaneous start.
REQ-020 In ARMED, start=1 (load=0) SHALL enter RUN with phase counter cyc=0; key=key1, slot=0, key_valid=1 visible after that same edge (zero added latency).
REQ-021 In RUN, cyc SHALL count 0..2*SLOT_LEN-1 and wrap to 0; key=key1/slot=0 for cyc<SLOT_LEN, else key=key2/slot=1.
REQ-022 In RUN, stop=1 SHALL enter ARMED; key SHALL be 0, key_valid=0, slot=0 after that edge; cyc SHALL be cleared.
REQ-023 In RUN, load=1 SHALL be ignored, pulse err once per rising edge of load, and not alter keys; start SHALL be ignored.
REQ-024 Simultaneous stop and load in RUN: stop SHALL be taken, load ignored, err pulsed.
REQ-025 Outside RUN, key SHALL be all-zero and key_valid=0.
REQ-026 bit_cnt SHALL be wide enough for 2*KEY_W without overflow; cyc for 2*SLOT_LEN-1.

Reset
REQ-027 With rst=1 at a rising edge the block SHALL enter IDLE; key=0, key_valid=0, slot=0, loaded=0, err=0, key1=key2=0, bit_cnt=0, cyc=0.
REQ-028 rst SHALL override every other input, including mid-LOAD and mid-RUN; no err pulse on reset.
REQ-029 The phase counter SHALL restart at 0 only through reset or a new start, so a shared rst aligns it with the downstream FSM's phase counter.

Verification
REQ-030 Reset, then load=1 for 10 cycles with sdi=0,1,0,1,1,1,1,1,0,1 -> loaded=1 after the 10th edge, key1=5'b01011, key2=5'b11101, err=0.
REQ-031 After REQ-030, start for 1 cycle, run 8 cycles -> key sequence 01011,01011,11101,11101,01011,01011,11101,11101, key_valid=1, slot=0,0,1,1,0,0,1,1.
REQ-032 Load only 6 bits then drop load -> err=1 for exactly one cycle, state IDLE, loaded=0, key=0.
REQ-033 In RUN at cyc=2, assert stop -> next cycle key=0, key_valid=0, state ARMED; start again -> key=01011, slot=0.
REQ-034 In ARMED assert load and start together -> LOAD entered, loaded=0, key_valid stays 0.
REQ-035 Assert rst mid-RUN at cyc=3 -> next cycle all outputs 0, loaded=0; start alone then has no effect until a full reload.
